// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative square-root engine between NREQ requesters.
// One job in flight at a time; a stuck engine is cut off by a timeout and reported via rsp_err.
module sqrt_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_rad,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]           rsp_root,
    output logic [WIDTH-1:0]           rsp_rem,
    output logic                       rsp_err,
    output logic                       eng_start,
    output logic [WIDTH-1:0]           eng_rad,
    input  logic                       eng_valid,
    input  logic [WIDTH-1:0]           eng_root,
    input  logic [WIDTH-1:0]           eng_rem
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           r_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_gnt_id;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rad;
    logic             r_eng_start;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_root;
    logic [WIDTH-1:0] r_rsp_rem;
    logic             r_rsp_err;

    logic             w_found;
    logic [IDW-1:0]   w_gnt_idx;

    // Search starts one past the last grant so every held request is reached within NREQ jobs.
    always_comb begin
        logic [IDW-1:0] w_idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((32'(r_last) + i) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == StIdle) && w_found) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_last      <= IDW'(NREQ - 1);
            r_gnt_id    <= '0;
            r_cnt       <= '0;
            r_rad       <= '0;
            r_eng_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_root  <= '0;
            r_rsp_rem   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_gnt_id    <= w_gnt_idx;
                        r_last      <= w_gnt_idx;
                        r_rad       <= req_rad[w_gnt_idx*WIDTH +: WIDTH];
                        r_eng_start <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // A result arriving on the last permitted cycle still beats the timeout.
                    if (eng_valid) begin
                        r_rsp_root  <= eng_root;
                        r_rsp_rem   <= eng_rem;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= r_gnt_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_root  <= '0;
                        r_rsp_rem   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_gnt_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_rad   = r_rad;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_root  = r_rsp_root;
    assign rsp_rem   = r_rsp_rem;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural engine plus a round-robin/isqrt reference model,
// directed scenarios followed by randomized jobs.
module tb_sqrt_arbiter;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int TOUT = 16;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_rad;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_root;
    logic [W-1:0]   rsp_rem;
    logic           rsp_err;
    logic           eng_start;
    logic [W-1:0]   eng_rad;
    logic           e_valid;
    logic [W-1:0]   e_root;
    logic [W-1:0]   e_rem;
    logic [2:0]     e_cnt;
    logic           eng_hold;

    int checks = 0;
    int errors = 0;
    int model_last = N - 1;

    sqrt_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rad   (req_rad),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_root  (rsp_root),
        .rsp_rem   (rsp_rem),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_rad   (eng_rad),
        .eng_valid (e_valid),
        .eng_root  (e_root),
        .eng_rem   (e_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Engine takes W/2 cycles; its valid level stays high until the next start.
    always @(posedge clk) begin
        if (eng_start) begin
            e_valid <= 1'b0;
            e_cnt   <= eng_hold ? 3'd0 : 3'(W / 2 - 1);
            e_root  <= W'(isqrt(int'(eng_rad)));
            e_rem   <= W'(int'(eng_rad) - isqrt(int'(eng_rad)) * isqrt(int'(eng_rad)));
        end else if (e_cnt != 3'd0) begin
            e_cnt <= e_cnt - 3'd1;
            if (e_cnt == 3'd1) e_valid <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_job(input logic [N-1:0] mask, input bit fix_rad, input logic [W-1:0] rad_in,
                          input int bp, input bit tmo);
        int          g;
        int          cyc;
        int          exp_root;
        int          exp_rem;
        int          exp_lat;
        bit          bad;
        logic [W-1:0] rad;
        g = rr_pick(mask, model_last);
        for (int k = 0; k < N; k++) req_rad[k*W +: W] = W'($urandom_range(0, 255));
        rad = fix_rad ? rad_in : req_rad[g*W +: W];
        req_rad[g*W +: W] = rad;
        eng_hold  = tmo;
        rsp_ready = 1'b0;
        req_valid = mask;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << g));
        model_last = g;
        exp_root = tmo ? 0 : isqrt(int'(rad));
        exp_rem  = tmo ? 0 : int'(rad) - exp_root * exp_root;
        exp_lat  = tmo ? TOUT + 2 : W / 2 + 2;
        tick();
        chk("eng_start", 32'(eng_start), 32'd1);
        chk("eng_rad", 32'(eng_rad), 32'(rad));
        cyc = 1;
        bad = 1'b0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (req_ready !== '0 || eng_start !== 1'b0) bad = 1'b1;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_root", 32'(rsp_root), 32'(exp_root));
        chk("rsp_rem", 32'(rsp_rem), 32'(exp_rem));
        chk("rsp_err", 32'(rsp_err), 32'(tmo));
        for (int b = 0; b < bp; b++) begin
            tick();
            if (rsp_valid !== 1'b1 || int'(rsp_id) != g || int'(rsp_root) != exp_root ||
                int'(rsp_rem) != exp_rem || rsp_err !== tmo || req_ready !== '0 ||
                eng_start !== 1'b0) bad = 1'b1;
        end
        chk("busy_quiet", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("persist_root", 32'(rsp_root), 32'(exp_root));
        chk("eng_rad_hold", 32'(eng_rad), 32'(rad));
    endtask

    initial begin
        bit quiet;
        int g;
        rst_n     = 1'b0;
        req_valid = '0;
        req_rad   = '0;
        rsp_ready = 1'b0;
        eng_hold  = 1'b0;
        e_valid   = 1'b0;
        e_cnt     = 3'd0;
        e_root    = '0;
        e_rem     = '0;
        repeat (2) tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_root", 32'(rsp_root), 32'd0);
        chk("rst_rsp_rem", 32'(rsp_rem), 32'd0);
        chk("rst_eng_rad", 32'(eng_rad), 32'd0);
        rst_n = 1'b1;
        tick();

        do_job(4'b0100, 1'b1, 8'd49, 0, 1'b0);
        do_job(4'b0001, 1'b1, 8'd200, 0, 1'b0);
        do_job(4'b0010, 1'b1, 8'd255, 0, 1'b0);
        do_job(4'b1000, 1'b1, 8'd0, 0, 1'b0);

        repeat (5) do_job(4'b1111, 1'b0, 8'd0, 0, 1'b0);
        repeat (3) do_job(4'b1010, 1'b0, 8'd0, 0, 1'b0);

        do_job(4'b1111, 1'b0, 8'd0, 10, 1'b0);
        do_job(4'b0110, 1'b0, 8'd0, 0, 1'b1);
        do_job(4'b0110, 1'b0, 8'd0, 0, 1'b0);

        // Abort a job two cycles into WAIT; the late engine result must be ignored.
        req_valid = 4'b0100;
        req_rad   = {4{8'd81}};
        eng_hold  = 1'b0;
        #1;
        g = rr_pick(4'b0100, model_last);
        chk("abort_grant", 32'(req_ready), 32'(1 << g));
        repeat (3) tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        model_last = N - 1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_eng_start", 32'(eng_start), 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        chk("abort_rsp_root", 32'(rsp_root), 32'd0);
        chk("abort_eng_rad", 32'(eng_rad), 32'd0);
        quiet = 1'b0;
        repeat (8) begin
            tick();
            if (rsp_valid !== 1'b0 || eng_start !== 1'b0) quiet = 1'b1;
        end
        chk("abort_no_rsp", 32'(quiet), 32'd0);
        do_job(4'b1111, 1'b0, 8'd0, 0, 1'b0);

        repeat (20) begin
            do_job(4'($urandom_range(1, 15)), 1'b0, 8'd0, $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the radicand, root and remainder width and match the shared sqrt engine.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters; the legal range is 2..8.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before a timeout; it SHALL be greater than WIDTH/2.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be a synchronous, active-low reset.
REQ-006 Port req_valid, input, NREQ bits, SHALL carry one request-valid bit per requester.
REQ-007 Port req_rad, input, NREQ*WIDTH bits, SHALL carry the radicands; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port req_ready, output, NREQ bits, SHALL be the one-hot grant/accept strobe.
REQ-009 Port rsp_valid, output, 1 bit, SHALL indicate that the response fields are valid.
REQ-010 Port rsp_ready, input, 1 bit, SHALL indicate that the consumer accepts the response.
REQ-011 Port rsp_id, output, clog2(NREQ) bits, SHALL give the index of the requester that originated the response.
REQ-012 Port rsp_root and port rsp_rem, outputs, WIDTH bits each, SHALL carry the result.
REQ-013 Port rsp_err, output, 1 bit, SHALL flag a timeout (no result).
REQ-014 Port eng_start, output, 1 bit, SHALL be the one-cycle start pulse to the engine.
REQ-015 Port eng_rad, output, WIDTH bits, SHALL be the engine radicand.
REQ-016 Port eng_valid, input, 1 bit, SHALL be the engine result-valid level.
REQ-017 Ports eng_root and eng_rem, inputs, WIDTH bits each, SHALL carry the engine results.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with any req_valid set, the block SHALL grant one requester by round-robin, starting the search at (last_grant+1) mod NREQ.
REQ-020 On the grant, the block SHALL drive req_ready[g]=1 combinationally in that cycle only, latch req_rad[g] and g, set last_grant=g, and go to ISSUE.
REQ-021 In IDLE with no req_valid set, req_ready SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-022 req_ready SHALL be 0 in every state other than IDLE, and at most one bit of req_ready SHALL be set at a time.
REQ-023 In ISSUE, eng_start SHALL be 1 for exactly one cycle, eng_rad SHALL equal the latched radicand, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-024 eng_rad SHALL hold its latched value from ISSUE until the next grant.
REQ-025 In WAIT, eng_valid=1 SHALL cause eng_root and eng_rem to be captured, rsp_err to be set to 0, and the FSM to go to RESP.
REQ-026 eng_valid SHALL be ignored in all states except WAIT, because a stale high level from the previous job is cleared by the start edge.
REQ-027 In WAIT with eng_valid=0, the timeout counter SHALL increment each cycle.
REQ-028 When the timeout counter reaches TIMEOUT-1 without eng_valid, the block SHALL set rsp_root=0, rsp_rem=0 and rsp_err=1, and go to RESP.
REQ-029 If eng_valid=1 in the same cycle the count reaches TIMEOUT-1, the result SHALL win and rsp_err SHALL be 0.
REQ-030 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_root, rsp_rem and rsp_err SHALL be stable until rsp_valid && rsp_ready.
REQ-031 On rsp_valid && rsp_ready, the FSM SHALL go to IDLE; rsp_valid SHALL fall on the next cycle and the response field values SHALL persist.
REQ-032 A back-to-back grant SHALL occur no earlier than the cycle after the RESP handshake.
REQ-033 Nominal latency SHALL be: grant at cycle 0, eng_start at cycle 1, rsp_valid at cycle WIDTH/2+2 (6 for WIDTH=8), given an engine with WIDTH/2 iterations.
REQ-034 A requester that drops req_valid before it is granted SHALL simply not be granted, and no other state change SHALL result.
REQ-035 The round-robin pointer SHALL wrap from NREQ-1 to 0.
REQ-036 Requesters that are not set SHALL be skipped in round-robin order, with no starvation: any held request SHALL be granted within NREQ transactions.

Reset
REQ-037 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, last_grant SHALL become NREQ-1 (requester 0 has first priority), and the timeout counter SHALL become 0.
REQ-038 Reset SHALL set eng_start, req_ready, rsp_valid and rsp_err to 0, and rsp_id, rsp_root, rsp_rem and eng_rad to 0.
REQ-039 A reset during ISSUE, WAIT or RESP SHALL abandon the job with no response emitted; any late eng_valid SHALL be ignored, and the engine is restarted by the next eng_start.

Verification
REQ-040 Single request: requester 2, rad=49 -> req_ready[2] at cycle 0, eng_start at cycle 1, rsp_valid at cycle 6 with id=2, root=7, rem=0, err=0.
REQ-041 Arithmetic sweep: rad=200 -> root=14, rem=4; rad=255 -> root=15, rem=30; rad=0 -> root=0, rem=0.
REQ-042 Round robin: all four req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0; then with only 1 and 3 set -> 1,3,1.
REQ-043 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and all rsp fields stable, no req_ready and no eng_start; release -> handshake, then a grant on the following cycle.
REQ-044 Timeout: engine model holds eng_valid=0 -> rsp_valid 16 cycles after entering WAIT with err=1, root=0, rem=0; the next job completes normally.
REQ-045 Reset mid-WAIT: rst_n=0 for 1 cycle at WAIT cycle 2 -> IDLE with all outputs 0, no rsp_valid for the aborted job, and the next grant goes to requester 0 if it is requesting.
